seg7_monitor: RTL and testbench

SEG7_MONITOR -- requirements
Module: seg7_monitor

---
 rtl/seg7_monitor.sv | 141 ++++++++++++++
 tb/tb_seg7_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_monitor.sv
// seg7_monitor: watches a 7-segment digit stage, debounces the segment bus,
// decodes it to BCD and checks that the digit only ever steps by +1 modulo
// (MAX_DIGIT+1). It reports each update, each carry, illegal patterns, and
// holds a sticky sequence-error flag.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   INIT  | nothing accepted since reset, valid low, no sequence check
//   LOCK  | a legal digit has been accepted, valid high, steps checked
module seg7_monitor #(
  parameter int MAX_DIGIT     = 5,
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       clr_err,
  output logic [3:0] digit,
  output logic       valid,
  output logic       digit_stb,
  output logic       wrap,
  output logic       illegal,
  output logic       seq_err
);

  typedef enum logic {INIT, LOCK} state_t;

  localparam logic [3:0] MAX_D   = 4'(MAX_DIGIT);
  localparam logic [3:0] RUN_TGT = 4'(STABLE_CYCLES);

  state_t     state, state_n;
  logic [6:0] sample;
  logic [3:0] run_cnt;
  logic       run_done;
  logic       stable_evt;
  logic [3:0] dec_val;
  logic       dec_hit;
  logic       legal;
  logic [3:0] exp_next;
  logic [3:0] digit_n;
  logic       valid_n, stb_n, wrap_n, ill_n, err_n;

  // A run is acted on once, in the first cycle its count reaches the target;
  // run_done suppresses re-triggering while the same pattern is held.
  assign stable_evt = (run_cnt == RUN_TGT) && !run_done;

  // Sample the bus and track how long the current sample has been constant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample   <= 7'b1111111;
      run_cnt  <= 4'd0;
      run_done <= 1'b0;
    end else begin
      sample <= seg_in;
      if (seg_in != sample) begin
        run_cnt  <= 4'd1;
        run_done <= 1'b0;
      end else begin
        if (run_cnt < RUN_TGT) run_cnt <= run_cnt + 4'd1;
        if (stable_evt) run_done <= 1'b1;
      end
    end
  end

  // Active-low segment decode, bit6=g .. bit0=a.
  always_comb begin
    dec_val = 4'd0;
    dec_hit = 1'b1;
    case (sample)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0010000: dec_val = 4'd9;
      default:    dec_hit = 1'b0;
    endcase
  end

  assign legal    = dec_hit && (dec_val <= MAX_D);
  assign exp_next = (digit == MAX_D) ? 4'd0 : digit + 4'd1;

  // Next-state and registered-output values; pulses default low.
  always_comb begin
    state_n = state;
    digit_n = digit;
    stb_n   = 1'b0;
    wrap_n  = 1'b0;
    ill_n   = 1'b0;
    err_n   = clr_err ? 1'b0 : seq_err;
    if (stable_evt) begin
      if (!legal) begin
        ill_n = 1'b1;
      end else begin
        case (state)
          INIT: begin
            state_n = LOCK;
            digit_n = dec_val;
            stb_n   = 1'b1;
          end
          LOCK: begin
            if (dec_val != digit) begin
              digit_n = dec_val;
              stb_n   = 1'b1;
              wrap_n  = (digit == MAX_D) && (dec_val == 4'd0);
              if (dec_val != exp_next) err_n = 1'b1;
            end
          end
          default: state_n = INIT;
        endcase
      end
    end
    valid_n = (state_n == LOCK);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      digit     <= 4'd0;
      valid     <= 1'b0;
      digit_stb <= 1'b0;
      wrap      <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_n;
      digit     <= digit_n;
      valid     <= valid_n;
      digit_stb <= stb_n;
      wrap      <= wrap_n;
      illegal   <= ill_n;
      seq_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor: a small reference model predicts every
// pulse (cycle, kind, digit) into a queue; a monitor pops and compares each
// pulse the DUT produces. Level outputs are checked at chosen points.
module tb_seg7_monitor;

  localparam int MAXD = 5;
  localparam int STAB = 2;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P8 = 7'b0000000;

  typedef struct packed {
    logic [31:0] cyc;
    logic        stb;
    logic        wrp;
    logic        ill;
    logic [3:0]  dig;
  } ev_t;

  logic       clk, rst, clr_err;
  logic [6:0] seg_in;
  logic [3:0] digit;
  logic       valid, digit_stb, wrap, illegal, seq_err;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] cyc = 0;
  ev_t         sb[$];

  logic [3:0] m_digit;
  logic       m_valid, m_err;
  logic [6:0] m_prev;

  seg7_monitor #(.MAX_DIGIT(MAXD), .STABLE_CYCLES(STAB)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .clr_err(clr_err),
    .digit(digit), .valid(valid), .digit_stb(digit_stb), .wrap(wrap),
    .illegal(illegal), .seq_err(seq_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Returns {hit, value}; hit=0 for a pattern outside the decode table.
  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    case (p)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      default:    return 5'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_digit = 4'd0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_prev  = 7'b1111111;
  endtask

  // Called at a falling edge: drive p, predict its outcome, hold for 'hold' cycles.
  task automatic drive(input logic [6:0] p, input int hold);
    logic [4:0] d;
    logic [3:0] nx;
    ev_t        e;
    seg_in = p;
    if (hold >= STAB && p != m_prev) begin
      d     = ref_decode(p);
      e.cyc = cyc + 32'd1 + 32'(STAB);
      e.stb = 1'b0;
      e.wrp = 1'b0;
      e.ill = 1'b0;
      e.dig = m_digit;
      if (!d[4] || int'(d[3:0]) > MAXD) begin
        e.ill = 1'b1;
        sb.push_back(e);
      end else if (!m_valid) begin
        e.stb = 1'b1;
        e.dig = d[3:0];
        m_valid = 1'b1;
        m_digit = d[3:0];
        sb.push_back(e);
      end else if (d[3:0] != m_digit) begin
        nx    = (int'(m_digit) == MAXD) ? 4'd0 : m_digit + 4'd1;
        e.stb = 1'b1;
        e.wrp = (int'(m_digit) == MAXD) && (d[3:0] == 4'd0);
        e.dig = d[3:0];
        if (d[3:0] != nx) m_err = 1'b1;
        m_digit = d[3:0];
        sb.push_back(e);
      end
    end
    m_prev = p;
    repeat (hold) @(negedge clk);
  endtask

  // Every pulse cycle must match the next predicted event exactly.
  always @(negedge clk) begin
    ev_t got, exp;
    if (!rst && (digit_stb || wrap || illegal)) begin
      got = '{cyc: cyc, stb: digit_stb, wrp: wrap, ill: illegal, dig: digit};
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL unexpected_pulse observed=%0h expected=no pulse", got);
      end else begin
        exp = sb.pop_front();
        assert (got === exp) else begin
          fails++;
          $error("FAIL pulse observed=%0h expected=%0h", got, exp);
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    clr_err = 1'b0;
    seg_in  = 7'b1111111;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_stb", 32'(digit_stb), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);

    rst = 1'b0;
    drive(P0, 4);
    chk("init_valid", 32'(valid), 32'd1);
    chk("init_digit", 32'(digit), 32'd0);
    chk("init_err", 32'(seq_err), 32'd0);

    drive(P1, 4); drive(P2, 4); drive(P3, 4);
    drive(P4, 4); drive(P5, 4); drive(P0, 4);
    chk("count_digit", 32'(digit), 32'd0);
    chk("count_err", 32'(seq_err), 32'(m_err));

    drive(P1, 4); drive(P2, 4);
    drive(P5, 4);
    chk("skip_digit", 32'(digit), 32'd5);
    chk("skip_err_set", 32'(seq_err), 32'(m_err));
    repeat (2) @(negedge clk);
    chk("skip_err_sticky", 32'(seq_err), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_err   = 1'b0;
    chk("clr_err", 32'(seq_err), 32'(m_err));

    drive(P0, 4); drive(P1, 4); drive(P2, 4); drive(P3, 4);
    drive(P8, 1);
    drive(P4, 4);
    chk("glitch_digit", 32'(digit), 32'd4);

    drive(P6, 5);
    chk("illegal_digit", 32'(digit), 32'd4);
    chk("illegal_valid", 32'(valid), 32'd1);
    drive(P4, 4);
    drive(P5, 4);
    chk("after_illegal_digit", 32'(digit), 32'd5);
    chk("after_illegal_err", 32'(seq_err), 32'd0);

    seg_in = P0;
    m_prev = P0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_digit", 32'(digit), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_stb", 32'(digit_stb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(P0, 4);
    chk("reacq_digit", 32'(digit), 32'd0);
    chk("reacq_valid", 32'(valid), 32'd1);

    repeat (4) @(negedge clk);
    chk("missing_events", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
